// File: rtl/iu_result_collector.sv
// Result collector: buffers integer-unit results in a small FIFO, drains them through
// one register-file write port and pulses the retired instruction id to the scoreboard.
module iu_result_collector #(
  parameter int NumTags     = 8,
  parameter int RegWidth    = 32,
  parameter int WarpWidth   = 4,
  parameter int NumWarps    = 8,
  parameter int RegIdxWidth = 8,
  parameter int FifoDepth   = 4,
  localparam int TagWidth   = $clog2(NumTags),
  localparam int WidWidth   = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int IidWidth   = TagWidth + WidWidth
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  output logic                          rc_to_eu_ready_o,
  input  logic                          eu_to_rc_valid_i,
  input  logic [IidWidth-1:0]           eu_to_rc_tag_i,
  input  logic [RegIdxWidth-1:0]        eu_to_rc_dst_i,
  input  logic [WarpWidth-1:0]          eu_to_rc_act_mask_i,
  input  logic [RegWidth*WarpWidth-1:0] eu_to_rc_data_i,
  output logic                          rc_to_rf_valid_o,
  input  logic                          rf_to_rc_ready_i,
  output logic [WidWidth-1:0]           rc_to_rf_wid_o,
  output logic [RegIdxWidth-1:0]        rc_to_rf_dst_o,
  output logic [WarpWidth-1:0]          rc_to_rf_mask_o,
  output logic [RegWidth*WarpWidth-1:0] rc_to_rf_data_o,
  output logic                          rc_to_sb_valid_o,
  output logic [IidWidth-1:0]           rc_to_sb_iid_o,
  output logic                          rc_empty_o
);

  localparam int PtrWidth  = $clog2(FifoDepth);
  localparam int CntWidth  = PtrWidth + 1;
  localparam int DataWidth = RegWidth * WarpWidth;
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(FifoDepth);

  logic [IidWidth-1:0]    tag_mem  [FifoDepth];
  logic [RegIdxWidth-1:0] dst_mem  [FifoDepth];
  logic [WarpWidth-1:0]   mask_mem [FifoDepth];
  logic [DataWidth-1:0]   data_mem [FifoDepth];

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                sb_valid_q, sb_valid_d;
  logic [IidWidth-1:0] sb_iid_q, sb_iid_d;

  logic                   empty, ready, push, pop;
  logic [IidWidth-1:0]    head_tag;
  logic [RegIdxWidth-1:0] head_dst;
  logic [WarpWidth-1:0]   head_mask;
  logic [DataWidth-1:0]   head_data;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    empty     = (count_q == '0);
    ready     = (count_q != FullCnt);
    push      = eu_to_rc_valid_i && ready;
    head_tag  = tag_mem[rd_ptr_q];
    head_dst  = dst_mem[rd_ptr_q];
    head_mask = mask_mem[rd_ptr_q];
    head_data = data_mem[rd_ptr_q];
    // An all-inactive result has nothing to write and retires without waiting on the RF.
    pop       = !empty && ((head_mask == '0) || rf_to_rc_ready_i);

    wr_ptr_d   = push ? wr_ptr_q + PtrWidth'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PtrWidth'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CntWidth'(1);
    if (!push && pop) count_d = count_q - CntWidth'(1);
    sb_valid_d = pop;
    sb_iid_d   = pop ? head_tag : sb_iid_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sb_valid_q <= 1'b0;
      sb_iid_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sb_valid_q <= sb_valid_d;
      sb_iid_q   <= sb_iid_d;
    end
  end

  // NOTE: payload storage has no reset; an entry is only read once count_q marks it valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[wr_ptr_q]  <= eu_to_rc_tag_i;
      dst_mem[wr_ptr_q]  <= eu_to_rc_dst_i;
      mask_mem[wr_ptr_q] <= eu_to_rc_act_mask_i;
      data_mem[wr_ptr_q] <= eu_to_rc_data_i;
    end
  end

  assign rc_to_eu_ready_o = ready;
  assign rc_to_rf_valid_o = !empty && (head_mask != '0);
  assign rc_to_rf_wid_o   = head_tag[WidWidth-1:0];
  assign rc_to_rf_dst_o   = head_dst;
  assign rc_to_rf_mask_o  = head_mask;
  assign rc_to_rf_data_o  = head_data;
  assign rc_to_sb_valid_o = sb_valid_q;
  assign rc_to_sb_iid_o   = sb_iid_q;
  assign rc_empty_o       = empty;

`ifndef SYNTHESIS
  logic                                            prev_stall_q;
  logic [WidWidth+RegIdxWidth+WarpWidth+DataWidth-1:0] prev_payload_q;
  logic [WidWidth+RegIdxWidth+WarpWidth+DataWidth-1:0] payload;

  assign payload = {rc_to_rf_wid_o, rc_to_rf_dst_o, rc_to_rf_mask_o, rc_to_rf_data_o};

  always_ff @(posedge clk_i) begin
    prev_stall_q   <= !rst_i && rc_to_rf_valid_o && !rf_to_rc_ready_i;
    prev_payload_q <= payload;
    if (!rst_i) begin
      assert (!(push && (count_q == FullCnt)));
      assert (count_q <= FullCnt);
      if (prev_stall_q) assert (rc_to_rf_valid_o && (payload == prev_payload_q));
    end
  end
`endif

endmodule

// File: tb/tb_iu_result_collector.sv
// Self-checking bench for iu_result_collector: directed timing checks plus a
// scoreboard that matches every RF write and completion against accepted inputs.
module tb_iu_result_collector;

  localparam int RegIdxWidth = 8;
  localparam int WarpWidth   = 4;
  localparam int WidWidth    = 3;
  localparam int IidWidth    = 6;
  localparam int DataWidth   = 128;

  typedef logic [127:0] val_t;
  typedef struct {
    logic [IidWidth-1:0]    iid;
    logic [RegIdxWidth-1:0] dst;
    logic [WarpWidth-1:0]   mask;
    logic [DataWidth-1:0]   data;
  } exp_t;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   rc_to_eu_ready_o;
  logic                   eu_to_rc_valid_i = 1'b0;
  logic [IidWidth-1:0]    eu_to_rc_tag_i = '0;
  logic [RegIdxWidth-1:0] eu_to_rc_dst_i = '0;
  logic [WarpWidth-1:0]   eu_to_rc_act_mask_i = '0;
  logic [DataWidth-1:0]   eu_to_rc_data_i = '0;
  logic                   rc_to_rf_valid_o;
  logic                   rf_to_rc_ready_i = 1'b0;
  logic [WidWidth-1:0]    rc_to_rf_wid_o;
  logic [RegIdxWidth-1:0] rc_to_rf_dst_o;
  logic [WarpWidth-1:0]   rc_to_rf_mask_o;
  logic [DataWidth-1:0]   rc_to_rf_data_o;
  logic                   rc_to_sb_valid_o;
  logic [IidWidth-1:0]    rc_to_sb_iid_o;
  logic                   rc_empty_o;

  iu_result_collector dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .rc_to_eu_ready_o    (rc_to_eu_ready_o),
    .eu_to_rc_valid_i    (eu_to_rc_valid_i),
    .eu_to_rc_tag_i      (eu_to_rc_tag_i),
    .eu_to_rc_dst_i      (eu_to_rc_dst_i),
    .eu_to_rc_act_mask_i (eu_to_rc_act_mask_i),
    .eu_to_rc_data_i     (eu_to_rc_data_i),
    .rc_to_rf_valid_o    (rc_to_rf_valid_o),
    .rf_to_rc_ready_i    (rf_to_rc_ready_i),
    .rc_to_rf_wid_o      (rc_to_rf_wid_o),
    .rc_to_rf_dst_o      (rc_to_rf_dst_o),
    .rc_to_rf_mask_o     (rc_to_rf_mask_o),
    .rc_to_rf_data_o     (rc_to_rf_data_o),
    .rc_to_sb_valid_o    (rc_to_sb_valid_o),
    .rc_to_sb_iid_o      (rc_to_sb_iid_o),
    .rc_empty_o          (rc_empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string name, input val_t obs, input val_t exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  exp_t rf_q[$];
  exp_t sb_q[$];

  // Inputs change at posedge+1, so the falling edge sees a settled cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      rf_q.delete();
      sb_q.delete();
    end else begin
      if (rc_to_rf_valid_o && rf_to_rc_ready_i) begin
        if (rf_q.size() == 0) begin
          check("rf_unexpected", val_t'(1), val_t'(0));
        end else begin
          e = rf_q.pop_front();
          check("rf_wid",  val_t'(rc_to_rf_wid_o),  val_t'(e.iid[WidWidth-1:0]));
          check("rf_dst",  val_t'(rc_to_rf_dst_o),  val_t'(e.dst));
          check("rf_mask", val_t'(rc_to_rf_mask_o), val_t'(e.mask));
          check("rf_data", val_t'(rc_to_rf_data_o), val_t'(e.data));
        end
      end
      if (rc_to_sb_valid_o) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", val_t'(1), val_t'(0));
        end else begin
          e = sb_q.pop_front();
          check("sb_iid", val_t'(rc_to_sb_iid_o), val_t'(e.iid));
        end
      end
      if (eu_to_rc_valid_i && rc_to_eu_ready_o) begin
        e.iid  = eu_to_rc_tag_i;
        e.dst  = eu_to_rc_dst_i;
        e.mask = eu_to_rc_act_mask_i;
        e.data = eu_to_rc_data_i;
        sb_q.push_back(e);
        if (e.mask != '0) rf_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [IidWidth-1:0] tag, input logic [RegIdxWidth-1:0] dst,
                       input logic [WarpWidth-1:0] mask, input logic [DataWidth-1:0] data);
    eu_to_rc_valid_i    = 1'b1;
    eu_to_rc_tag_i      = tag;
    eu_to_rc_dst_i      = dst;
    eu_to_rc_act_mask_i = mask;
    eu_to_rc_data_i     = data;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rf_q.size() != 0 || sb_q.size() != 0 || !rc_empty_o); i++) tick();
    tick();
    check("drain_rf_q", val_t'(rf_q.size()), val_t'(0));
    check("drain_sb_q", val_t'(sb_q.size()), val_t'(0));
  endtask

  function automatic logic [DataWidth-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DataWidth-1:0] first_data;

    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_rf_valid", val_t'(rc_to_rf_valid_o), val_t'(0));
    check("rst_sb_valid", val_t'(rc_to_sb_valid_o), val_t'(0));
    check("rst_sb_iid",   val_t'(rc_to_sb_iid_o),   val_t'(0));
    check("rst_empty",    val_t'(rc_empty_o),       val_t'(1));
    check("rst_ready",    val_t'(rc_to_eu_ready_o), val_t'(1));

    // Single result: RF request one cycle after push, completion one cycle later
    rf_to_rc_ready_i = 1'b1;
    drive(6'h0B, 8'd5, 4'b1111, {32'd4, 32'd3, 32'd2, 32'd1});
    tick();
    eu_to_rc_valid_i = 1'b0;
    check("t1_rf_valid", val_t'(rc_to_rf_valid_o), val_t'(1));
    check("t1_rf_wid",   val_t'(rc_to_rf_wid_o),   val_t'(3));
    check("t1_rf_dst",   val_t'(rc_to_rf_dst_o),   val_t'(5));
    check("t1_rf_mask",  val_t'(rc_to_rf_mask_o),  val_t'(4'b1111));
    check("t1_sb_early", val_t'(rc_to_sb_valid_o), val_t'(0));
    tick();
    check("t1_sb_valid", val_t'(rc_to_sb_valid_o), val_t'(1));
    check("t1_sb_iid",   val_t'(rc_to_sb_iid_o),   val_t'(6'h0B));
    check("t1_empty",    val_t'(rc_empty_o),       val_t'(1));
    tick();
    check("t1_sb_pulse", val_t'(rc_to_sb_valid_o), val_t'(0));
    check("t1_iid_hold", val_t'(rc_to_sb_iid_o),   val_t'(6'h0B));

    // Back-pressure: fill, hold payload, refuse push while full even as a pop happens
    rf_to_rc_ready_i = 1'b0;
    first_data = rand_data();
    for (int i = 0; i < 4; i++) begin
      drive(6'(6'h20 + i), 8'(8'h40 + i), 4'(i + 1), (i == 0) ? first_data : rand_data());
      tick();
    end
    check("full_ready", val_t'(rc_to_eu_ready_o), val_t'(0));
    check("full_empty", val_t'(rc_empty_o),       val_t'(0));
    drive(6'h24, 8'h44, 4'b1000, rand_data());
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_ready",    val_t'(rc_to_eu_ready_o), val_t'(0));
      check("stall_rf_valid", val_t'(rc_to_rf_valid_o), val_t'(1));
      check("stall_rf_dst",   val_t'(rc_to_rf_dst_o),   val_t'(8'h40));
      check("stall_rf_data",  val_t'(rc_to_rf_data_o),  val_t'(first_data));
    end
    rf_to_rc_ready_i = 1'b1;
    tick();
    check("pop_ready_back", val_t'(rc_to_eu_ready_o), val_t'(1));
    check("pop_next_head",  val_t'(rc_to_rf_dst_o),   val_t'(8'h41));
    tick();
    eu_to_rc_valid_i = 1'b0;
    drain();

    // Inactive mask: no RF request, retires even with the RF stalled
    rf_to_rc_ready_i = 1'b0;
    drive(6'h12, 8'd9, 4'b0000, rand_data());
    tick();
    eu_to_rc_valid_i = 1'b0;
    check("m0_rf_valid", val_t'(rc_to_rf_valid_o), val_t'(0));
    check("m0_sb_early", val_t'(rc_to_sb_valid_o), val_t'(0));
    tick();
    check("m0_sb_valid", val_t'(rc_to_sb_valid_o), val_t'(1));
    check("m0_sb_iid",   val_t'(rc_to_sb_iid_o),   val_t'(6'h12));
    check("m0_empty",    val_t'(rc_empty_o),       val_t'(1));
    rf_to_rc_ready_i = 1'b1;
    drain();

    // Streaming at full rate across pointer wrap
    for (int c = 0; c <= 10; c++) begin
      if (c < 10) drive(6'(6'h30 + c), 8'(c), 4'($urandom_range(1, 15)), rand_data());
      else eu_to_rc_valid_i = 1'b0;
      tick();
      check("stream_rf_valid", val_t'(rc_to_rf_valid_o), val_t'(c < 10));
      check("stream_sb_valid", val_t'(rc_to_sb_valid_o), val_t'(c >= 1));
      check("stream_ready",    val_t'(rc_to_eu_ready_o), val_t'(1));
    end
    drain();

    // Reset with buffered entries discards them without completions
    rf_to_rc_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(6'(6'h38 + i), 8'(8'h80 + i), 4'b0101, rand_data());
      tick();
    end
    eu_to_rc_valid_i = 1'b0;
    check("pre_rst_empty", val_t'(rc_empty_o), val_t'(0));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_rf_valid", val_t'(rc_to_rf_valid_o), val_t'(0));
    check("mid_rst_sb_valid", val_t'(rc_to_sb_valid_o), val_t'(0));
    check("mid_rst_empty",    val_t'(rc_empty_o),       val_t'(1));
    check("mid_rst_ready",    val_t'(rc_to_eu_ready_o), val_t'(1));
    rf_to_rc_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_stale_sb", val_t'(rc_to_sb_valid_o), val_t'(0));
      check("no_stale_rf", val_t'(rc_to_rf_valid_o), val_t'(0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
